// File: rtl/seg_scan.sv
// seg_scan: multiplexes a DIGITS-wide hex value onto a common-anode 7-segment display
// Advances one digit per refresh transition and reloads a per-frame shadow copy
// of value/dp on wrap to digit 0, so a displayed frame never mixes two values.
// Ports: clk, rst (sync, active-high), refresh (divider level), en (display enable),
//   value (hex nibbles, digit i = value[4i+3:4i]), dp (per-digit decimal point),
//   an (active-low anodes, registered), seg (active-low {dp,g..a}, registered),
//   frame (one-cycle pulse on shadow reload).
// Option: define SEG_SCAN_LZ_BLANK_EN for leading-zero blanking.
module seg_scan #(
  parameter int DIGITS = 4,
  parameter int IDXW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  refresh,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame
);
  localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);
  logic refresh_d, tick, blank;
  logic [IDXW-1:0] idx;
  logic [4*DIGITS-1:0] sval;
  logic [DIGITS-1:0] sdp;
  logic [3:0] nib;
  logic [6:0] hex;
  assign tick = refresh ^ refresh_d;
  assign nib = sval[{idx, 2'b00} +: 4];
  always_comb begin
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      default: hex = 7'h0E;
    endcase
  end
`ifdef SEG_SCAN_LZ_BLANK_EN
  // lz[i] is set when every shadow nibble from i up to the top digit is zero
  logic [DIGITS-1:0] lz;
  logic all_zero;
  always_comb begin
    lz = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (sval[4*i +: 4] == 4'd0);
      lz[i] = all_zero;
    end
  end
  assign blank = (idx != '0) && lz[idx] && !sdp[idx];
`else
  assign blank = 1'b0;
`endif
  // refresh_d tracks refresh even in reset/disable so neither release creates a tick
  always_ff @(posedge clk) begin
    refresh_d <= refresh;
    if (rst) begin
      idx <= LAST;
      sval <= '0;
      sdp <= '0;
      an <= '1;
      seg <= 8'hFF;
      frame <= 1'b0;
    end else begin
      frame <= tick && en && (idx == LAST);
      if (tick && en) begin
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
        if (idx == LAST) begin
          sval <= value;
          sdp <= dp;
        end
      end
      an <= (!en || blank) ? '1 : ~(DIGITS'(1) << idx);
      seg <= (!en || blank) ? 8'hFF : {~sdp[idx], hex};
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: cycle-model scoreboard bench for seg_scan
module tb_seg_scan;
  localparam int D = 4;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct packed {
    logic frame;
    logic [D-1:0] an;
    logic [7:0] seg;
  } exp_t;
  logic clk = 1'b0, rst, refresh, en, frame;
  logic [4*D-1:0] value;
  logic [D-1:0] dp, an;
  logic [7:0] seg;
  exp_t sb[$];
  int n_vec = 0, n_bad = 0;
  int m_idx = D - 1;
  logic m_rd = 1'b0;
  logic [4*D-1:0] m_sv = '0;
  logic [D-1:0] m_sd = '0;
  seg_scan #(.DIGITS(D), .IDXW(2)) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .en(en), .value(value), .dp(dp),
    .an(an), .seg(seg), .frame(frame)
  );
  always #5 clk = ~clk;
  function automatic logic m_blank();
`ifdef SEG_SCAN_LZ_BLANK_EN
    return m_idx != 0 && !m_sd[m_idx] && (m_sv >> (4 * m_idx)) == '0;
`else
    return 1'b0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit t);
    exp_t e;
    logic tk;
    if (t) refresh = ~refresh;
    tk = (refresh ^ m_rd) && en && !rst;
    e.frame = !rst && tk && m_idx == D - 1;
    e.an = (rst || !en || m_blank()) ? '1 : ~(4'b1 << m_idx);
    e.seg = (rst || !en || m_blank()) ? 8'hFF : {~m_sd[m_idx], HEX[m_sv[4*m_idx +: 4]]};
    sb.push_back(e);
    m_rd = refresh;
    if (rst) begin
      m_idx = D - 1;
      m_sv = '0;
      m_sd = '0;
    end else if (tk) begin
      if (m_idx == D - 1) begin
        m_idx = 0;
        m_sv = value;
        m_sd = dp;
      end else m_idx++;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("frame", 32'(frame), 32'(e.frame));
    chk("an", 32'(an), 32'(e.an));
    chk("seg", 32'(seg), 32'(e.seg));
    @(negedge clk);
  endtask
  task automatic step();
    cyc(1);
    cyc(0);
  endtask
  initial begin
    rst = 1'b1;
    refresh = 1'b0;
    en = 1'b1;
    value = 16'h1230;
    dp = '0;
    @(negedge clk);
    repeat (3) cyc(0);
    cyc(1);
    rst = 1'b0;
    cyc(0);
    cyc(0);
    step();
    chk("first_an", 32'(an), 32'h0000000E);
    chk("first_seg", 32'(seg), 32'h000000C0);
    value = 16'h1234;
    dp = 4'b0100;
    repeat (8) step();
    cyc(1);
    value = 16'hABCD;
    repeat (4) step();
    chk("abcd_an", 32'(an), 32'h0000000D);
    chk("abcd_seg", 32'(seg), 32'h000000C6);
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    cyc(0);
    cyc(0);
    step();
    rst = 1'b1;
    cyc(0);
    rst = 1'b0;
    cyc(0);
    cyc(0);
    step();
    repeat (20) cyc(0);
    for (int k = 0; k < 7; k++) step();
    value = 16'h0042;
    dp = '0;
    repeat (8) step();
    value = 16'h0000;
    repeat (8) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
